// File: rtl/cpu_pkg.sv
// Shared definitions for the single-issue MIPS core: bus defaults and the
// fetch FSM state encoding.
package cpu_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned IMEM_DEPTH_DEF = 128;
    localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, neither means hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc4,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc4,
    output logic            o_valid
);

    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc4;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst  <= NOP_WORD;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_inst  <= NOP_WORD;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM and next-PC mux feeding IF/ID.
// Optional out-of-range fetch trap enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter logic [XLEN-1:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] IMinst_addr,
    input  logic [XLEN-1:0] IMinst,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            if_id_valid,
    output logic [XLEN-1:0] pc,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] DEPTH_W = XLEN'(IMEM_DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_inc;
    logic            r_fault;
    logic            w_fault_set;
    logic            w_load;
    logic            w_bubble;
    logic            w_out_of_range;
    logic            w_unused;

    assign w_pc_inc       = r_pc + 32'd4;
    assign w_out_of_range = {2'b00, r_pc[XLEN-1:2]} >= DEPTH_W;
    // Byte-offset bits of the target are dropped by design.
    assign w_unused       = ^{redirect_pc[1:0], w_out_of_range};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_fault <= r_fault | w_fault_set;
        end
    end

    // Priority: redirect > flush > stall > normal fetch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_fault_set  = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    w_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
                    w_bubble  = 1'b1;
                end else if (flush) begin
                    w_bubble = 1'b1;
                    if (!stall) begin
                        w_pc_next = w_pc_inc;
                    end
                end else if (stall) begin
                    w_load = 1'b0;
                end else begin
`ifdef FETCH_BOUNDS_CHECK_EN
                    if (w_out_of_range) begin
                        w_bubble     = 1'b1;
                        w_fault_set  = 1'b1;
                        w_state_next = ST_FAULT;
                    end else begin
                        w_load    = 1'b1;
                        w_pc_next = w_pc_inc;
                    end
`else
                    w_load    = 1'b1;
                    w_pc_next = w_pc_inc;
`endif
                end
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            ST_FAULT: begin
                w_bubble = 1'b1;
            end
`endif
            default: begin
                w_state_next = ST_BOOT;
                w_bubble     = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_inst   (IMinst),
        .i_pc4    (w_pc_inc),
        .o_inst   (if_id_inst),
        .o_pc4    (if_id_pc4),
        .o_valid  (if_id_valid)
    );

    assign IMinst_addr = {2'b00, r_pc[XLEN-1:2]};
    assign pc          = r_pc;
    assign fetch_fault = r_fault;

endmodule
